delay_chain: RTL and testbench

DELAY_CHAIN -- requirements
Module: delay_chain

---
 rtl/delay_chain.sv | 87 ++++++++
 tb/tb_delay_chain.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/delay_chain.sv
// delay_chain: delays a data word and its valid flag by DEL_CYC_LEN enabled
// clock cycles. The delay only counts edges where clk_en is high.
// DEL_CYC_LEN = 0 turns the block into a plain wire from inputs to outputs.
// Reset is synchronous and active-low. It always clears the valid stages.
// Optional macro DELAY_CHAIN_DATA_RST_EN: when defined, reset also clears the
// data stages to zero. When undefined, the data stages have no reset, so
// synthesis is free to map them onto shift-register primitives.
module delay_chain #(
    parameter int IN_WORD_WDT = 8,
    parameter int DEL_CYC_LEN = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_en,
    input  logic [IN_WORD_WDT-1:0] in_word,
    input  logic                   in_word_val,
    output logic [IN_WORD_WDT-1:0] in_word_del,
    output logic                   in_word_val_del
);

    generate
        if (DEL_CYC_LEN == 0) begin : g_bypass

            // Zero delay: both outputs follow their inputs combinationally.
            assign in_word_del     = in_word;
            assign in_word_val_del = in_word_val;

        end else begin : g_chain

            logic [IN_WORD_WDT-1:0] data_q [DEL_CYC_LEN];
            logic [DEL_CYC_LEN-1:0] val_q;

            // Valid chain: reset clears it whatever clk_en is; otherwise it
            // shifts on enabled edges.
            // NOTE: sequential state uses non-blocking assignments. Every stage
            // then samples its predecessor's value from before the edge, which
            // is what makes this a true shift register.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    val_q <= '0;
                end else if (clk_en) begin
                    val_q[0] <= in_word_val;
                    for (int k = 1; k < DEL_CYC_LEN; k++) begin
                        val_q[k] <= val_q[k-1];
                    end
                end
            end

`ifdef DELAY_CHAIN_DATA_RST_EN
            // Data chain with reset: clears to zero, otherwise shifts on
            // enabled edges. Invalid words are carried through unchanged.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < DEL_CYC_LEN; k++) begin
                        data_q[k] <= '0;
                    end
                end else if (clk_en) begin
                    data_q[0] <= in_word;
                    for (int k = 1; k < DEL_CYC_LEN; k++) begin
                        data_q[k] <= data_q[k-1];
                    end
                end
            end
`else
            // Data chain without reset: shifts on enabled edges. Invalid words
            // are carried through unchanged.
            // NOTE: the data storage is deliberately left unreset. A reset
            // input would stop it mapping to a shift-register primitive, and
            // the valid chain already marks stale words as invalid.
            always_ff @(posedge clk) begin
                if (clk_en) begin
                    data_q[0] <= in_word;
                    for (int k = 1; k < DEL_CYC_LEN; k++) begin
                        data_q[k] <= data_q[k-1];
                    end
                end
            end
`endif

            // The last stage drives the outputs, so they are registered.
            assign in_word_del     = data_q[DEL_CYC_LEN-1];
            assign in_word_val_del = val_q[DEL_CYC_LEN-1];

        end
    endgenerate

endmodule

// File: tb/tb_delay_chain.sv
// tb_delay_chain: directed bench for delay_chain.
// It instantiates delays of 3, 2, 0 and 4 cycles side by side on one clock.
// The data-reset checks follow the DELAY_CHAIN_DATA_RST_EN macro.
module tb_delay_chain;

    logic clk;
    logic rst_n;

    // N=3, W=8
    logic       en3;
    logic [7:0] d3;
    logic       v3;
    logic [7:0] d3_del;
    logic       v3_del;

    // N=2, W=8
    logic       en2;
    logic [7:0] d2;
    logic       v2;
    logic [7:0] d2_del;
    logic       v2_del;

    // N=0, W=16
    logic        en0;
    logic [15:0] d0;
    logic        v0;
    logic [15:0] d0_del;
    logic        v0_del;

    // N=4, W=8
    logic       en4;
    logic [7:0] d4;
    logic       v4;
    logic [7:0] d4_del;
    logic       v4_del;

    int n_chk  = 0;
    int n_fail = 0;

    delay_chain #(.IN_WORD_WDT(8), .DEL_CYC_LEN(3)) u_n3 (
        .clk(clk), .rst_n(rst_n), .clk_en(en3), .in_word(d3), .in_word_val(v3),
        .in_word_del(d3_del), .in_word_val_del(v3_del)
    );

    delay_chain #(.IN_WORD_WDT(8), .DEL_CYC_LEN(2)) u_n2 (
        .clk(clk), .rst_n(rst_n), .clk_en(en2), .in_word(d2), .in_word_val(v2),
        .in_word_del(d2_del), .in_word_val_del(v2_del)
    );

    delay_chain #(.IN_WORD_WDT(16), .DEL_CYC_LEN(0)) u_n0 (
        .clk(clk), .rst_n(rst_n), .clk_en(en0), .in_word(d0), .in_word_val(v0),
        .in_word_del(d0_del), .in_word_val_del(v0_del)
    );

    delay_chain #(.IN_WORD_WDT(8), .DEL_CYC_LEN(4)) u_n4 (
        .clk(clk), .rst_n(rst_n), .clk_en(en4), .in_word(d4), .in_word_val(v4),
        .in_word_del(d4_del), .in_word_val_del(v4_del)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: an immediate assertion that counts and reports misses.
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge; outputs settle 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected N=3 outputs while clk_en toggles 1,0,1,0,... then three flush edges.
    logic [7:0] t26_d [11];
    logic       t26_v [11];

    // Reference queue for the N=4 run.
    logic [7:0] q_d [$];
    logic       q_v [$];
    logic [7:0] e_d;
    logic       e_v;

    initial begin
        t26_d = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h04, 8'h00};
        t26_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        en3 = 1'b0; d3 = 8'h00; v3 = 1'b0;
        en2 = 1'b0; d2 = 8'h00; v2 = 1'b0;
        en0 = 1'b0; d0 = 16'h0000; v0 = 1'b0;
        en4 = 1'b0; d4 = 8'h00; v4 = 1'b0;

        // Zero-delay instance: a pure wire, even while reset is held and no edge has occurred.
        d0 = 16'hBEEF; v0 = 1'b1;
        #1;
        check("n0_data_beef", d0_del, 16'hBEEF);
        check("n0_val_1", {15'd0, v0_del}, 16'd1);
        d0 = 16'h1234; v0 = 1'b0; en0 = 1'b1;
        #1;
        check("n0_data_1234", d0_del, 16'h1234);
        check("n0_val_0", {15'd0, v0_del}, 16'd0);

        // Reset state.
        step();
        step();
        check("rst_n3_val", {15'd0, v3_del}, 16'd0);
        check("rst_n2_val", {15'd0, v2_del}, 16'd0);
        check("rst_n4_val", {15'd0, v4_del}, 16'd0);
`ifdef DELAY_CHAIN_DATA_RST_EN
        check("rst_n3_data", {8'd0, d3_del}, 16'd0);
        check("rst_n4_data", {8'd0, d4_del}, 16'd0);
`endif
        rst_n = 1'b1;

        // N=3 single-cycle pulse: emerges exactly 3 edges later, for one cycle.
        en3 = 1'b1; d3 = 8'hA5; v3 = 1'b1;
        step();
        d3 = 8'h00; v3 = 1'b0;
        check("pulse_e1_val", {15'd0, v3_del}, 16'd0);
        step();
        check("pulse_e2_val", {15'd0, v3_del}, 16'd0);
        step();
        check("pulse_e3_data", {8'd0, d3_del}, 16'h00A5);
        check("pulse_e3_val", {15'd0, v3_del}, 16'd1);
        step();
        check("pulse_e4_data", {8'd0, d3_del}, 16'h0000);
        check("pulse_e4_val", {15'd0, v3_del}, 16'd0);

        // N=3 with clk_en toggling: each word is presented on an enabled edge, then held.
        for (int i = 0; i < 11; i++) begin
            if (i < 8) begin
                en3 = (i % 2 == 0);
                d3  = 8'(i / 2 + 1);
                v3  = 1'b1;
            end else begin
                en3 = 1'b1;
                d3  = 8'h00;
                v3  = 1'b0;
            end
            step();
            check($sformatf("toggle_%0d_data", i), {8'd0, d3_del}, {8'd0, t26_d[i]});
            check($sformatf("toggle_%0d_val", i), {15'd0, v3_del}, {15'd0, t26_v[i]});
        end

        // N=2: fill with valid words, then reset with clk_en low.
        en2 = 1'b1; d2 = 8'h11; v2 = 1'b1;
        step();
        d2 = 8'h22;
        step();
        check("n2_fill_11", {8'd0, d2_del}, 16'h0011);
        check("n2_fill_val", {15'd0, v2_del}, 16'd1);
        d2 = 8'h33;
        step();
        check("n2_fill_22", {8'd0, d2_del}, 16'h0022);
        en2 = 1'b0; rst_n = 1'b0;
        // Hold clk_en high on the N=3 instance to show that reset overrides shifting.
        en3 = 1'b1; d3 = 8'h77; v3 = 1'b1;
        step();
        rst_n = 1'b1; en3 = 1'b0; v3 = 1'b0;
        check("n2_rst_val", {15'd0, v2_del}, 16'd0);
        check("n3_rst_en_val", {15'd0, v3_del}, 16'd0);
`ifdef DELAY_CHAIN_DATA_RST_EN
        check("n2_rst_data", {8'd0, d2_del}, 16'd0);
        check("n3_rst_en_data", {8'd0, d3_del}, 16'd0);
`endif
        // First valid input after reset appears 2 enabled edges later.
        en2 = 1'b1; d2 = 8'h44; v2 = 1'b1;
        step();
        check("n2_post_e1_val", {15'd0, v2_del}, 16'd0);
        d2 = 8'h55; v2 = 1'b0;
        step();
        check("n2_post_e2_data", {8'd0, d2_del}, 16'h0044);
        check("n2_post_e2_val", {15'd0, v2_del}, 16'd1);
        step();
        check("n2_post_e3_data", {8'd0, d2_del}, 16'h0055);
        check("n2_post_e3_val", {15'd0, v2_del}, 16'd0);

        // N=4 random traffic with ~70% enable, compared against a queue model.
        for (int i = 0; i < 60; i++) begin
            en4 = ($urandom_range(0, 9) < 7);
            d4  = 8'($urandom_range(0, 255));
            v4  = 1'($urandom_range(0, 1));
            if (en4) begin
                q_d.push_back(d4);
                q_v.push_back(v4);
            end
            step();
            if (q_d.size() > 4) begin
                void'(q_d.pop_front());
                void'(q_v.pop_front());
            end
            if (q_d.size() == 4) begin
                e_d = q_d[0];
                e_v = q_v[0];
                check($sformatf("rand_%0d_data", i), {8'd0, d4_del}, {8'd0, e_d});
                check($sformatf("rand_%0d_val", i), {15'd0, v4_del}, {15'd0, e_v});
            end else begin
                check($sformatf("rand_%0d_val_fill", i), {15'd0, v4_del}, 16'd0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
